// File: rtl/ddr_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr_arb_pkg
// Shared definitions for the two-port DDR line arbiter:
//   - state_t      : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   - DEF_ADDR_W   : default line-address width
//   - DEF_LINE_W   : default line width (4 x 32-bit words)
//   - PORT_I/PORT_D: port indices (instruction cache = 0, data cache = 1)
//   - arb_pick()   : choose a port from the two pending flags
// ---------------------------------------------------------------------------
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_LINE_W = 128;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // With both ports pending the tie goes to 'favour'; otherwise the only
    // pending port wins. Result is meaningless when neither is pending.
    function automatic logic arb_pick(input logic pend_i,
                                      input logic pend_d,
                                      input logic favour);
        if (pend_i && pend_d) begin
            return favour;
        end
        return pend_d ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/ddr_arb_port.sv
// ---------------------------------------------------------------------------
// ddr_arb_port
// One-entry pending slot for a single requester of the DDR arbiter.
// A request pulse captures {we, addr, wdata}; the slot clears when the
// arbiter grants it. A pulse arriving while the slot is still pending (and
// not being granted this cycle) is dropped and flagged on o_overrun.
//
// Ports:
//   clk, rstn      : clock, synchronous active-low reset
//   i_req          : one-cycle request pulse
//   i_we/i_addr/i_wdata : request payload, sampled with i_req
//   i_grant        : arbiter takes the slot contents this cycle
//   o_pending      : slot holds an ungranted request
//   o_we/o_addr/o_wdata : slot contents
//   o_overrun      : combinational, high for a dropped request pulse
// ---------------------------------------------------------------------------
module ddr_arb_port
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic              i_grant,
    output logic              o_pending,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LINE_W-1:0] o_wdata,
    output logic              o_overrun
);

    logic              r_pending;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;

    // The slot frees up on the grant edge, so a pulse in the grant cycle
    // itself is accepted rather than treated as an overrun.
    logic w_accept;
    assign w_accept  = i_req && (!r_pending || i_grant);
    assign o_overrun = i_req && r_pending && !i_grant;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pending <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
            r_we      <= i_we;
            r_addr    <= i_addr;
            r_wdata   <= i_wdata;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_we      = r_we;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;

endmodule

// File: rtl/ddr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_arbiter
// Arbitrates line requests from the instruction cache (p0) and the data
// cache (p1) onto a single DDR command interface, one transaction at a time.
//
// Build option:
//   DDR_ARB_RR_EN  defined   -> round-robin arbitration (tie goes to the port
//                               not granted last; pointer starts favouring p1)
//                  undefined -> fixed priority, p1 over p0
//
// Ports:
//   clk, rstn                  : clock, synchronous active-low reset
//   pN_req/pN_we/pN_addr/pN_wdata : request pulse + payload, N = 0, 1
//   pN_fin                     : one-cycle completion pulse
//   pN_rdata                   : read line, held until next completion on N
//   ddr_rd_en/ddr_wr_en        : one-cycle DDR command pulses
//   ddr_addr/ddr_wr_data       : command payload, held until next grant
//   ddr_rd_fin/ddr_wr_fin      : DDR completion strobes
//   ddr_rd_data                : read line, valid with ddr_rd_fin
//   err                        : sticky protocol-violation flag
//
// Timing: pulse sampled at E0, grant at E1 (ddr_*_en high after E1), DDR fin
// sampled at E2 at the earliest, pN_fin high after E3.
// ---------------------------------------------------------------------------
module ddr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [LINE_W-1:0] p0_wdata,
    output logic              p0_fin,
    output logic [LINE_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [LINE_W-1:0] p1_wdata,
    output logic              p1_fin,
    output logic [LINE_W-1:0] p1_rdata,

    output logic              ddr_rd_en,
    output logic              ddr_wr_en,
    output logic [ADDR_W-1:0] ddr_addr,
    output logic [LINE_W-1:0] ddr_wr_data,
    input  logic              ddr_rd_fin,
    input  logic              ddr_wr_fin,
    input  logic [LINE_W-1:0] ddr_rd_data,

    output logic              err
);

    // ---------------- pending slots ----------------
    logic [1:0]        w_pend;
    logic [1:0]        w_slot_we;
    logic [1:0]        w_ovr;
    logic [1:0]        w_grant;
    logic [ADDR_W-1:0] w_slot_addr  [2];
    logic [LINE_W-1:0] w_slot_wdata [2];

    ddr_arb_port #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_port_i (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (p0_req),
        .i_we      (p0_we),
        .i_addr    (p0_addr),
        .i_wdata   (p0_wdata),
        .i_grant   (w_grant[PORT_I]),
        .o_pending (w_pend[PORT_I]),
        .o_we      (w_slot_we[PORT_I]),
        .o_addr    (w_slot_addr[PORT_I]),
        .o_wdata   (w_slot_wdata[PORT_I]),
        .o_overrun (w_ovr[PORT_I])
    );

    ddr_arb_port #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_port_d (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (p1_req),
        .i_we      (p1_we),
        .i_addr    (p1_addr),
        .i_wdata   (p1_wdata),
        .i_grant   (w_grant[PORT_D]),
        .o_pending (w_pend[PORT_D]),
        .o_we      (w_slot_we[PORT_D]),
        .o_addr    (w_slot_addr[PORT_D]),
        .o_wdata   (w_slot_wdata[PORT_D]),
        .o_overrun (w_ovr[PORT_D])
    );

    // ---------------- arbitration ----------------
    logic w_favour;
    logic w_gnt_port;
    logic w_do_grant;

`ifdef DDR_ARB_RR_EN
    logic r_rr_favour;

    // Pointer names the port that wins the next tie: the one not granted last.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr_favour <= PORT_D;
        end else if (w_do_grant) begin
            r_rr_favour <= ~w_gnt_port;
        end
    end

    assign w_favour = r_rr_favour;
`else
    assign w_favour = PORT_D;
`endif

    assign w_gnt_port      = arb_pick(w_pend[PORT_I], w_pend[PORT_D], w_favour);
    assign w_grant[PORT_I] = w_do_grant && (w_gnt_port == PORT_I);
    assign w_grant[PORT_D] = w_do_grant && (w_gnt_port == PORT_D);

    // ---------------- FSM ----------------
    state_t r_state;
    state_t w_state_nx;
    logic   r_we;         // granted transaction is a write
    logic   r_gnt;        // granted port
    logic   w_fin_ok;     // matching DDR completion accepted this cycle
    logic   w_fin_bad;    // DDR completion that must be ignored and flagged
    logic   w_match_fin;
    logic   w_other_fin;

    assign w_match_fin = r_we ? ddr_wr_fin : ddr_rd_fin;
    assign w_other_fin = r_we ? ddr_rd_fin : ddr_wr_fin;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_do_grant = 1'b0;
        w_fin_ok   = 1'b0;
        w_fin_bad  = 1'b0;
        ddr_rd_en  = 1'b0;
        ddr_wr_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_fin_bad = ddr_rd_fin || ddr_wr_fin;
                if (|w_pend) begin
                    w_do_grant = 1'b1;
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                // Command pulse only in the single ISSUE cycle; a fin may
                // already arrive during it.
                ddr_rd_en  = (r_state == ST_ISSUE) && !r_we;
                ddr_wr_en  = (r_state == ST_ISSUE) &&  r_we;
                w_fin_bad  = w_other_fin;
                w_fin_ok   = w_match_fin;
                w_state_nx = w_match_fin ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                w_fin_bad  = ddr_rd_fin || ddr_wr_fin;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    logic [ADDR_W-1:0] r_ddr_addr;
    logic [LINE_W-1:0] r_ddr_wr_data;
    logic [LINE_W-1:0] r_rd_buf;     // DDR read line, held until DONE
    logic [LINE_W-1:0] r_p0_rdata;
    logic [LINE_W-1:0] r_p1_rdata;
    logic              r_p0_fin;
    logic              r_p1_fin;
    logic              r_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_we          <= 1'b0;
            r_gnt         <= PORT_I;
            r_ddr_addr    <= '0;
            r_ddr_wr_data <= '0;
            r_rd_buf      <= '0;
            r_p0_rdata    <= '0;
            r_p1_rdata    <= '0;
            r_p0_fin      <= 1'b0;
            r_p1_fin      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_p0_fin <= 1'b0;
            r_p1_fin <= 1'b0;

            if (w_do_grant) begin
                r_gnt         <= w_gnt_port;
                r_we          <= w_slot_we[w_gnt_port];
                r_ddr_addr    <= w_slot_addr[w_gnt_port];
                r_ddr_wr_data <= w_slot_wdata[w_gnt_port];
            end

            if (w_fin_ok && !r_we) begin
                r_rd_buf <= ddr_rd_data;
            end

            if (r_state == ST_DONE) begin
                if (r_gnt == PORT_I) begin
                    r_p0_fin <= 1'b1;
                    if (!r_we) r_p0_rdata <= r_rd_buf;
                end else begin
                    r_p1_fin <= 1'b1;
                    if (!r_we) r_p1_rdata <= r_rd_buf;
                end
            end

            if ((|w_ovr) || w_fin_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign p0_fin      = r_p0_fin;
    assign p1_fin      = r_p1_fin;
    assign p0_rdata    = r_p0_rdata;
    assign p1_rdata    = r_p1_rdata;
    assign ddr_addr    = r_ddr_addr;
    assign ddr_wr_data = r_ddr_wr_data;
    assign err         = r_err;

endmodule

// File: tb/tb_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_arbiter
// Scoreboard bench for ddr_arbiter. Stimulus tasks compute the expected DDR
// command order and completion data from the arbitration rules and push them
// into queues; a monitor pops and compares whenever the DUT raises a DDR
// command or a port completion. A DDR responder answers commands after a
// random delay with data derived from the address.
// ---------------------------------------------------------------------------
module tb_ddr_arbiter;

    localparam int AW = 27;
    localparam int LW = 128;
    localparam logic [LW-1:0] BEEF = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_1111;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic          port;
        logic [LW-1:0] rdata;
    } fin_t;

    logic          clk;
    logic          rstn;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [LW-1:0] p0_wdata, p1_wdata;
    logic          p0_fin, p1_fin;
    logic [LW-1:0] p0_rdata, p1_rdata;
    logic          ddr_rd_en, ddr_wr_en;
    logic [AW-1:0] ddr_addr;
    logic [LW-1:0] ddr_wr_data;
    logic          ddr_rd_fin, ddr_wr_fin;
    logic [LW-1:0] ddr_rd_data;
    logic          err;

    ddr_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_fin      (p0_fin),
        .p0_rdata    (p0_rdata),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_fin      (p1_fin),
        .p1_rdata    (p1_rdata),
        .ddr_rd_en   (ddr_rd_en),
        .ddr_wr_en   (ddr_wr_en),
        .ddr_addr    (ddr_addr),
        .ddr_wr_data (ddr_wr_data),
        .ddr_rd_fin  (ddr_rd_fin),
        .ddr_wr_fin  (ddr_wr_fin),
        .ddr_rd_data (ddr_rd_data),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state / reference model ----------------
    int            n_vec = 0;
    int            n_err = 0;
    cmd_t          exp_cmd[$];
    fin_t          exp_fin[$];
    logic          exp_err;
    logic          rr_fav;           // port that wins the next tie (RR build)
    logic [LW-1:0] last_rdata [2];   // what pN_rdata should currently show
    logic          ddr_auto;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, wanted %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected, or bound expired", name);
    endtask

    // DDR memory stand-in: read data is a fixed function of the address.
    function automatic logic [LW-1:0] rd_model(input logic [AW-1:0] a);
        return {4{a, 5'h15}} ^ 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    endfunction

    task automatic model_reset();
        exp_cmd.delete();
        exp_fin.delete();
        exp_err       = 1'b0;
        rr_fav        = 1'b1;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        cmd_t c;
        fin_t f;
        forever begin
            @(negedge clk);
            if (ddr_rd_en || ddr_wr_en) begin
                if (exp_cmd.size() == 0) begin
                    report_fail("unexpected_ddr_cmd");
                end else begin
                    c = exp_cmd.pop_front();
                    check_bit("ddr_en_onehot", ddr_rd_en & ddr_wr_en, 1'b0);
                    check_bit("ddr_cmd_we", ddr_wr_en, c.we);
                    check_vec("ddr_cmd_addr", LW'(ddr_addr), LW'(c.addr));
                    if (c.we) check_vec("ddr_cmd_wdata", ddr_wr_data, c.wdata);
                end
            end
            if (p0_fin || p1_fin) begin
                if (exp_fin.size() == 0) begin
                    report_fail("unexpected_port_fin");
                end else begin
                    f = exp_fin.pop_front();
                    check_bit("fin_onehot", p0_fin & p1_fin, 1'b0);
                    check_bit("fin_port", p1_fin, f.port);
                    check_vec("fin_rdata", f.port ? p1_rdata : p0_rdata, f.rdata);
                end
            end
        end
    end

    // ---------------- DDR responder ----------------
    initial begin : responder
        logic          w;
        logic [AW-1:0] a;
        int            d;
        forever begin
            @(negedge clk);
            if (ddr_auto && (ddr_rd_en || ddr_wr_en)) begin
                w = ddr_wr_en;
                a = ddr_addr;
                d = $urandom_range(0, 4);
                repeat (d) @(negedge clk);
                ddr_rd_data = w ? LW'({$urandom, $urandom}) : rd_model(a);
                ddr_rd_fin  = !w;
                ddr_wr_fin  = w;
                @(negedge clk);
                ddr_rd_fin  = 1'b0;
                ddr_wr_fin  = 1'b0;
                ddr_rd_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_fin.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) report_fail("drain_timeout");
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic wait_cmd(input string name);
        int n;
        n = 0;
        while (!(ddr_rd_en || ddr_wr_en) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) report_fail(name);
    endtask

    // Pulse the selected ports on one edge; the model orders service by the
    // arbitration rule. 'overrun' re-pulses p0 while its slot is still waiting
    // behind p1 (caller guarantees p1 wins the tie).
    task automatic run_batch(input logic want0, input logic want1,
                             input logic we0, input logic we1, input logic overrun);
        cmd_t c0, c1, c;
        fin_t f;
        int   order[$];
        c0.we = we0; c0.addr = AW'($urandom); c0.wdata = {$urandom, $urandom, $urandom, $urandom};
        c1.we = we1; c1.addr = AW'($urandom); c1.wdata = {$urandom, $urandom, $urandom, $urandom};
        if (want0 && want1) begin
`ifdef DDR_ARB_RR_EN
            order.push_back(int'(rr_fav));
            order.push_back(int'(!rr_fav));
`else
            order.push_back(1);
            order.push_back(0);
`endif
        end else if (want1) begin
            order.push_back(1);
        end else begin
            order.push_back(0);
        end
        foreach (order[k]) begin
            c = (order[k] == 1) ? c1 : c0;
            exp_cmd.push_back(c);
            f.port = (order[k] == 1);
            if (!c.we) last_rdata[order[k]] = rd_model(c.addr);
            f.rdata = last_rdata[order[k]];
            exp_fin.push_back(f);
            rr_fav = !f.port;
        end
        if (overrun) exp_err = 1'b1;

        @(negedge clk);
        p0_req = want0; p0_we = c0.we; p0_addr = c0.addr; p0_wdata = c0.wdata;
        p1_req = want1; p1_we = c1.we; p1_addr = c1.addr; p1_wdata = c1.wdata;
        @(negedge clk);
        p0_req = 1'b0;
        p1_req = 1'b0;
        if (overrun) begin
            @(negedge clk);
            p0_req = 1'b1; p0_we = ~c0.we; p0_addr = ~c0.addr; p0_wdata = ~c0.wdata;
            @(negedge clk);
            p0_req = 1'b0;
        end
        wait_drain();
        check_bit("err_after_batch", err, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_p0_fin"}, p0_fin, 1'b0);
        check_bit({tag, "_p1_fin"}, p1_fin, 1'b0);
        check_vec({tag, "_p0_rdata"}, p0_rdata, '0);
        check_vec({tag, "_p1_rdata"}, p1_rdata, '0);
        check_bit({tag, "_rd_en"}, ddr_rd_en, 1'b0);
        check_bit({tag, "_wr_en"}, ddr_wr_en, 1'b0);
        check_vec({tag, "_ddr_addr"}, LW'(ddr_addr), '0);
        check_vec({tag, "_ddr_wdata"}, ddr_wr_data, '0);
        check_bit({tag, "_err"}, err, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : stimulus
        cmd_t c;
        fin_t f;
        logic [LW-1:0] d035;

        rstn = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        ddr_rd_fin = 1'b0; ddr_wr_fin = 1'b0; ddr_rd_data = '0;
        ddr_auto = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        // Single p1 read, DDR answers late: latency and payload.
        c.we = 1'b0; c.addr = 27'h0000100; c.wdata = '0;
        exp_cmd.push_back(c);
        f.port = 1'b1; f.rdata = BEEF;
        exp_fin.push_back(f);
        last_rdata[1] = BEEF;
        rr_fav = 1'b0;
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 27'h0000100; p1_wdata = {4{32'hA5A5_5A5A}};
        @(negedge clk);
        p1_req = 1'b0;
        check_bit("lat_en_early", ddr_rd_en, 1'b0);
        @(negedge clk);
        check_bit("lat_rd_en", ddr_rd_en, 1'b1);
        check_bit("lat_no_wr_en", ddr_wr_en, 1'b0);
        check_vec("lat_addr", LW'(ddr_addr), LW'(27'h0000100));
        @(negedge clk);
        check_bit("lat_single_pulse", ddr_rd_en, 1'b0);
        repeat (4) @(negedge clk);
        ddr_rd_data = BEEF;
        ddr_rd_fin  = 1'b1;
        check_vec("lat_addr_held", LW'(ddr_addr), LW'(27'h0000100));
        @(negedge clk);
        ddr_rd_fin  = 1'b0;
        ddr_rd_data = '0;
        check_bit("lat_fin_early", p1_fin, 1'b0);
        @(negedge clk);
        check_bit("lat_p1_fin", p1_fin, 1'b1);
        check_vec("lat_p1_rdata", p1_rdata, BEEF);
        check_bit("lat_p0_fin", p0_fin, 1'b0);
        @(negedge clk);
        check_bit("lat_fin_single", p1_fin, 1'b0);
        check_vec("lat_rdata_held", p1_rdata, BEEF);
        wait_drain();

        // Simultaneous p0 write + p1 read, twice, then random traffic.
        ddr_auto = 1'b1;
        run_batch(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_batch(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic w0, w1;
            int   sel;
            sel = $urandom_range(1, 3);
            w0  = 1'($urandom);
            w1  = 1'($urandom);
            run_batch(sel[0], sel[1], w0, w1, 1'b0);
        end

        // Overrun on p0 while it waits behind p1.
        do_reset();
        run_batch(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Stray DDR fins: rd_fin in IDLE, wr_fin during a read.
        ddr_auto = 1'b0;
        do_reset();
        @(negedge clk);
        ddr_rd_fin = 1'b1;
        @(negedge clk);
        ddr_rd_fin = 1'b0;
        exp_err = 1'b1;
        @(negedge clk);
        check_bit("idle_fin_err", err, exp_err);
        d035 = {$urandom, $urandom, $urandom, $urandom};
        c.we = 1'b0; c.addr = AW'($urandom); c.wdata = '0;
        exp_cmd.push_back(c);
        f.port = 1'b0; f.rdata = d035;
        exp_fin.push_back(f);
        last_rdata[0] = d035;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = c.addr;
        @(negedge clk);
        p0_req = 1'b0;
        wait_cmd("stray_cmd_timeout");
        ddr_wr_fin = 1'b1;
        @(negedge clk);
        ddr_wr_fin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("stray_no_fin", p0_fin, 1'b0);
        end
        check_bit("stray_err", err, 1'b1);
        ddr_rd_data = d035;
        ddr_rd_fin  = 1'b1;
        @(negedge clk);
        ddr_rd_fin  = 1'b0;
        wait_drain();

        // Reset in WAIT: transaction abandoned, late fin flags err.
        do_reset();
        c.we = 1'b0; c.addr = AW'($urandom); c.wdata = '0;
        exp_cmd.push_back(c);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = c.addr;
        @(negedge clk);
        p0_req = 1'b0;
        wait_cmd("rst_cmd_timeout");
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rstn = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        ddr_rd_fin = 1'b1;
        @(negedge clk);
        ddr_rd_fin = 1'b0;
        exp_err = 1'b1;
        @(negedge clk);
        check_bit("late_fin_err", err, exp_err);
        ddr_auto = 1'b1;
        run_batch(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
